// File: rtl/uart_transmitter.sv
// uart_transmitter: byte FIFO feeding an 8N1 serial shifter timed by a shared
// 16x oversampling enable. Single clock domain, synchronous active-low reset.
module uart_transmitter #(
  parameter int unsigned SAMPLE_TIMES = 15,
  parameter int unsigned FIFO_ADDR_W  = 2
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       tx_clk_en,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_overflow,
  output logic       tx
);

  localparam int unsigned DEPTH  = 1 << FIFO_ADDR_W;
  localparam int unsigned CNT_W  = FIFO_ADDR_W + 1;
  localparam int unsigned TICK_W = (SAMPLE_TIMES > 0) ? $clog2(SAMPLE_TIMES + 1) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;

  logic [7:0]             mem_q [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [2:0]             state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   ovf_q, ovf_d;
  logic                   push_c, pop_c, tick_last_c, fifo_nonempty_c;

  assign tick_last_c     = (tick_q == TICK_W'(SAMPLE_TIMES));
  assign fifo_nonempty_c = (count_q != '0);

  // Next-state logic: FIFO accept/drop decisions and the bit-timing FSM
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop_c    = 1'b0;
    push_c   = tx_wr && (count_q < CNT_W'(DEPTH));
    ovf_d    = tx_wr && (count_q == CNT_W'(DEPTH));

    if (tx_clk_en) begin
      case (state_q)
        ST_IDLE: begin
          tx_d = 1'b1;
          if (fifo_nonempty_c) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            tick_d  = '0;
            state_d = ST_START;
            tx_d    = 1'b0;
          end
        end
        ST_START: begin
          tx_d = 1'b0;
          if (tick_last_c) begin
            tick_d  = '0;
            bit_d   = 3'd0;
            state_d = ST_DATA;
            tx_d    = shift_q[0];
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        ST_DATA: begin
          tx_d = shift_q[0];
          if (tick_last_c) begin
            tick_d = '0;
            if (bit_q == 3'd7) begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end else begin
              // tx takes the next bit now so it lines up with the shifted register
              shift_d = {1'b0, shift_q[7:1]};
              bit_d   = bit_q + 3'd1;
              tx_d    = shift_q[1];
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        ST_STOP: begin
          tx_d = 1'b1;
          if (tick_last_c) begin
            tick_d = '0;
            if (fifo_nonempty_c) begin
              // chain straight into the next start bit without an idle tick
              pop_c   = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = ST_START;
              tx_d    = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = '0;
          bit_d   = 3'd0;
          tx_d    = 1'b1;
        end
      endcase
    end

    wr_ptr_d = push_c ? wr_ptr_q + FIFO_ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + FIFO_ADDR_W'(1) : rd_ptr_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge sys_clk) begin
    if (rst_n && push_c) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign tx          = tx_q;
  assign tx_overflow = ovf_q;
  assign tx_full     = (count_q == CNT_W'(DEPTH));
  assign tx_busy     = fifo_nonempty_c || (state_q != ST_IDLE);

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit half of the board UART: accepts bytes from the host-side logic through a write strobe, buffers them in a small FIFO, and shifts them out on `tx` as 8N1 frames (1 start, 8 data LSB first, 1 stop). It runs entirely in the `sys_clk` domain. Bit timing comes from the shared 16x oversampling enable that also drives the UART receiver, so one baud generator serves both directions.

## Interface
- `SAMPLE_TIMES`, 15: `tx_clk_en` ticks per bit minus one; each bit lasts `SAMPLE_TIMES+1` ticks.
- `FIFO_ADDR_W`, 2: log2 of FIFO depth; default depth is 4 bytes.

- `sys_clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `tx_clk_en` in 1: 16x baud enable, one `sys_clk` cycle wide per tick.
- `tx_data` in 8: byte to transmit; sampled when `tx_wr` is high.
- `tx_wr` in 1: write strobe, one byte per cycle high.
- `tx_full` out 1: FIFO holds `2^FIFO_ADDR_W` bytes.
- `tx_busy` out 1: high while the FIFO is non-empty or the FSM is not IDLE.
- `tx_overflow` out 1: one-cycle pulse when a write is dropped.
- `tx` out 1: serial line, registered, idle high.

## Operation
- **Reset** (`rst_n`=0 at a clock edge): `tx`=1, state IDLE, FIFO pointers and count are 0, tick counter is 0, bit index is 0, `tx_overflow`=0, `tx_full`=0, `tx_busy`=0.
- **FIFO**:
  - Circular buffer with wrapping read/write pointers and a count of width `FIFO_ADDR_W+1`.
  - A write is accepted when `tx_wr`=1 and the registered count is below the depth.
  - When `tx_wr`=1 and the FIFO is full, the byte is dropped and `tx_overflow` pulses on the next cycle. This applies even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- **FSM** (advances only on cycles where `tx_clk_en`=1; holds all state otherwise):
  - IDLE: `tx`=1. If the count is above 0, pop the head byte into the shift register, clear the tick counter, and go to START.
  - START: `tx`=0 for `SAMPLE_TIMES+1` ticks, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0]. After `SAMPLE_TIMES+1` ticks, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for `SAMPLE_TIMES+1` ticks. At the end, if the count is above 0, pop and go directly to START with no idle gap; otherwise go to IDLE.
  - Unused state encodings return to IDLE with `tx`=1.
- The tick counter wraps from `SAMPLE_TIMES` to 0 at each bit boundary.
- The bit index saturates at 7 and cannot overrun.
- `tx_busy` and `tx_full` are combinational from the registered count and state.

## Timing
- Frame length is exactly `10*(SAMPLE_TIMES+1)` `tx_clk_en` ticks (160 at the default).
- Write-to-line latency from IDLE with an empty FIFO:
  - Write at cycle N; the count becomes 1 at N+1.
  - The first `tx_clk_en` at cycle ≥ N+1 pops the byte.
  - `tx` falls on the edge ending that tick cycle.
- Back-to-back frames: the stop bit of byte k is immediately followed by the start bit of byte k+1. There are no extra ticks between them.
- Popping in IDLE uses the count from before this cycle's write. A write into an empty FIFO is therefore never popped in the same cycle.
- Bit changes happen only on edges where `tx_clk_en`=1. Gaps in `tx_clk_en` stretch bits proportionally.
- Reset mid-frame:
  - `tx` returns to 1 on the reset edge.
  - Buffered bytes are discarded and the frame is abandoned.
  - Normal operation resumes on the first cycle with `rst_n`=1.

## Test plan
- **Single byte:** write 0x55 in IDLE with `tx_clk_en` every cycle. `tx` must produce the sequence 0,1,0,1,0,1,0,1,0,1 (start, then data LSB first, then stop), each bit 16 cycles. `tx_busy` must drop at the end of the stop bit.
- **Back-to-back:** write 0xA3 then 0x0F on consecutive cycles. Two frames must be 320 ticks total with no idle high between the stop of 0xA3 and the start of 0x0F. Sampled data must be 0xA3 then 0x0F.
- **Overflow:** hold `tx_clk_en`=0 and write 5 bytes 0x01..0x05. `tx_full` must be 1 after the 4th write, and `tx_overflow` must pulse once for 0x05. Releasing `tx_clk_en` must transmit only 0x01..0x04.
- **Enable gaps:** assert `tx_clk_en` one cycle in three and send 0xC3. Each bit must last 48 `sys_clk` cycles and the data must be correct.
- **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 of 0xFF with 2 bytes queued. `tx`, `tx_busy`, `tx_full` and `tx_overflow` must be 1, 0, 0, 0 after the reset edge, and there must be no further frames.
- **Simultaneous push/pop:** with a full FIFO, write at the exact STOP-end pop tick. The write must be dropped, `tx_overflow` must pulse, and the count must drop to 3.
